fastbconv_sk_bba_to_q: RTL and testbench

- Exact Shenoy–Kumaresan base conversion from the BBa basis back to the q basis.
- Sits directly downstream of the qBBa→BBa mod-switch stage: consumes its N_SLOTS x BBa_BASIS_LEN output vector and returns an N_SLOTS x q_BASIS_LEN vector, completing the modulus-down flow.
- BBa = B moduli (indices 0..B_BASIS_LEN-1) followed by one redundant modulus m_sk (index B_BASIS_LEN).
- Multi-cycle: serially walks B limbs, then computes the SK correction alpha, then emits the exact result.

---
 rtl/fastbconv_sk_bba_to_q_pkg.sv | 63 ++++++
 rtl/fastbconv_sk_bba_to_q_if.sv | 38 +++
 rtl/fastbconv_sk_bba_to_q_mod_mac_lane.sv | 28 ++
 rtl/fastbconv_sk_bba_to_q.sv | 185 ++++++++++++++++++
 tb/tb_fastbconv_sk_bba_to_q.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fastbconv_sk_bba_to_q_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fastbconv_sk_bba_to_q_pkg                                    |
// | Description : Shared types, basis constants and modular helpers for the    |
// |               Shenoy-Kumaresan BBa -> q base converter.                    |
// |               Basis: B = {7, 11}, m_sk = 13, q = {5, 3}.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fastbconv_sk_bba_to_q_pkg;

  localparam int RNS_PRIME_BITS = 8;
  localparam int B_BASIS_LEN    = 2;
  localparam int BBA_BASIS_LEN  = B_BASIS_LEN + 1;
  localparam int Q_BASIS_LEN    = 2;
  localparam int N_SLOTS        = 4;
  localparam int IDX_W          = (B_BASIS_LEN > 1) ? $clog2(B_BASIS_LEN) : 1;

  typedef logic [RNS_PRIME_BITS-1:0]   rns_residue_t;
  typedef logic [2*RNS_PRIME_BITS-1:0] wide_rns_residue_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_ALPHA   = 2'd2,
    ST_CORRECT = 2'd3
  } fbc_state_t;

  // B moduli and the redundant SK modulus.
  localparam rns_residue_t B_BASIS [B_BASIS_LEN] = '{8'd7, 8'd11};
  localparam rns_residue_t M_SK                  = 8'd13;
  // Output q moduli.
  localparam rns_residue_t Q_BASIS [Q_BASIS_LEN] = '{8'd5, 8'd3};

  // (B/b_i)^-1 mod b_i.
  localparam rns_residue_t ZB_MOD_B [B_BASIS_LEN] = '{8'd2, 8'd8};
  // (B/b_i) mod q_j, indexed [i][j].
  localparam rns_residue_t YB_TO_Q [B_BASIS_LEN][Q_BASIS_LEN] = '{'{8'd1, 8'd2},
                                                                 '{8'd2, 8'd1}};
  // (B/b_i) mod m_sk.
  localparam rns_residue_t YB_TO_SK [B_BASIS_LEN] = '{8'd11, 8'd7};
  // B^-1 mod m_sk (77 = -1 mod 13, so its inverse is 12).
  localparam rns_residue_t BINV_MOD_SK = 8'd12;
  // B mod q_j.
  localparam rns_residue_t B_MOD_Q [Q_BASIS_LEN] = '{8'd2, 8'd2};

  // Reduce a wide product into a residue of modulus m.
  function automatic rns_residue_t mod_reduce(input wide_rns_residue_t x,
                                              input rns_residue_t      m);
    return rns_residue_t'(x % wide_rns_residue_t'(m));
  endfunction

  // (a + b) mod m for a < m and b <= m; one extra bit avoids overflow.
  function automatic rns_residue_t add_mod(input rns_residue_t a,
                                           input rns_residue_t b,
                                           input rns_residue_t m);
    logic [RNS_PRIME_BITS:0] v_sum;
    v_sum = {1'b0, a} + {1'b0, b};
    if (v_sum >= {1'b0, m}) v_sum = v_sum - {1'b0, m};
    return rns_residue_t'(v_sum);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fastbconv_sk_bba_to_q_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fastbconv_sk_bba_to_q_if                                     |
// | Description : Start/result bus of the SK BBa -> q base converter.          |
// |   in_valid       : one-cycle start pulse (master -> slave)                 |
// |   input_RNSpoly  : BBa residues per slot, m_sk residue in the last limb    |
// |   busy           : conversion in flight (slave -> master)                  |
// |   out_valid      : one-cycle result pulse (slave -> master)                |
// |   output_RNSpoly : q residues per slot, held until the next result         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface fastbconv_sk_bba_to_q_if;
  import fastbconv_sk_bba_to_q_pkg::*;

  logic         in_valid;
  rns_residue_t input_RNSpoly  [N_SLOTS][BBA_BASIS_LEN];
  logic         busy;
  logic         out_valid;
  rns_residue_t output_RNSpoly [N_SLOTS][Q_BASIS_LEN];

  modport master (
    output in_valid,
    output input_RNSpoly,
    input  busy,
    input  out_valid,
    input  output_RNSpoly
  );

  modport slave (
    input  in_valid,
    input  input_RNSpoly,
    output busy,
    output out_valid,
    output output_RNSpoly
  );

endinterface
`default_nettype wire

// File: rtl/fastbconv_sk_bba_to_q_mod_mac_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mod_mac_lane                                                 |
// | Description : One residue multiply-accumulate: o_acc_next =                |
// |               (i_acc + i_a * i_b) mod MODULUS. Purely combinational.       |
// |   i_acc      : current accumulator, already < MODULUS                      |
// |   i_a, i_b   : operands (any residue width value)                          |
// |   o_acc_next : reduced accumulator                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mod_mac_lane
  import fastbconv_sk_bba_to_q_pkg::*;
#(
  parameter rns_residue_t MODULUS = rns_residue_t'(2)
) (
  input  rns_residue_t i_acc,
  input  rns_residue_t i_a,
  input  rns_residue_t i_b,
  output rns_residue_t o_acc_next
);

  rns_residue_t w_prod_red;

  assign w_prod_red = mod_reduce(wide_rns_residue_t'(i_a) * wide_rns_residue_t'(i_b), MODULUS);
  assign o_acc_next = add_mod(i_acc, w_prod_red, MODULUS);

endmodule
`default_nettype wire

// File: rtl/fastbconv_sk_bba_to_q.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fastbconv_sk_bba_to_q                                        |
// | Description : Exact Shenoy-Kumaresan base conversion BBa -> q.             |
// |               Walks the B limbs one per cycle accumulating into q and      |
// |               m_sk, derives the overflow count alpha from the redundant    |
// |               m_sk residue, then subtracts alpha*B in each q limb.         |
// |               Result appears B_BASIS_LEN+2 edges after the start edge.     |
// |   clk   : rising-edge clock                                                |
// |   reset : asynchronous, active-low                                         |
// |   bus   : slave side of fastbconv_sk_bba_to_q_if                           |
// | Build option: FASTBCONV_SK_CENTER_ALPHA_EN - treat alpha > m_sk/2 as       |
// |               alpha - m_sk (centered inputs |x| < B/2).                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fastbconv_sk_bba_to_q
  import fastbconv_sk_bba_to_q_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  fastbconv_sk_bba_to_q_if.slave bus
);

  fbc_state_t         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_busy;
  logic               r_out_valid;
  rns_residue_t       r_in       [N_SLOTS][BBA_BASIS_LEN];
  rns_residue_t       r_acc_q    [N_SLOTS][Q_BASIS_LEN];
  rns_residue_t       r_acc_sk   [N_SLOTS];
  rns_residue_t       r_alpha    [N_SLOTS];
  rns_residue_t       r_out      [N_SLOTS][Q_BASIS_LEN];

  rns_residue_t       w_y        [N_SLOTS][B_BASIS_LEN];
  rns_residue_t       w_y_sel    [N_SLOTS];
  rns_residue_t       w_acc_q_nxt[N_SLOTS][Q_BASIS_LEN];
  rns_residue_t       w_acc_sk_nxt[N_SLOTS];
  rns_residue_t       w_alpha_nxt[N_SLOTS];
  rns_residue_t       w_out_nxt  [N_SLOTS][Q_BASIS_LEN];

  // --------------------------------------------------------------------------
  // Accumulation datapath: every limb's y is precomputed against its own
  // constant modulus, then the current limb is selected by r_idx.
  // --------------------------------------------------------------------------
  for (genvar s = 0; s < N_SLOTS; s++) begin : g_slot
    for (genvar i = 0; i < B_BASIS_LEN; i++) begin : g_limb
      assign w_y[s][i] = mod_reduce(wide_rns_residue_t'(r_in[s][i]) *
                                    wide_rns_residue_t'(ZB_MOD_B[i]), B_BASIS[i]);
    end

    assign w_y_sel[s] = w_y[s][r_idx];

    for (genvar j = 0; j < Q_BASIS_LEN; j++) begin : g_q
      mod_mac_lane #(
        .MODULUS (Q_BASIS[j])
      ) u_lane_q (
        .i_acc      (r_acc_q[s][j]),
        .i_a        (w_y_sel[s]),
        .i_b        (YB_TO_Q[r_idx][j]),
        .o_acc_next (w_acc_q_nxt[s][j])
      );
    end

    mod_mac_lane #(
      .MODULUS (M_SK)
    ) u_lane_sk (
      .i_acc      (r_acc_sk[s]),
      .i_a        (w_y_sel[s]),
      .i_b        (YB_TO_SK[r_idx]),
      .o_acc_next (w_acc_sk_nxt[s])
    );

    for (genvar j = 0; j < Q_BASIS_LEN; j++) begin : g_out
      assign bus.output_RNSpoly[s][j] = r_out[s][j];
    end
  end

  // --------------------------------------------------------------------------
  // alpha = (acc_sk - x_sk) * B^-1 mod m_sk. The difference is formed signed
  // so a negative result can be folded back by adding m_sk once.
  // --------------------------------------------------------------------------
  always_comb begin
    logic signed [RNS_PRIME_BITS:0] v_diff;
    for (int s = 0; s < N_SLOTS; s++) begin
      v_diff = $signed({1'b0, r_acc_sk[s]}) - $signed({1'b0, r_in[s][B_BASIS_LEN]});
      if (v_diff < 0) v_diff = v_diff + $signed({1'b0, M_SK});
      w_alpha_nxt[s] = mod_reduce(wide_rns_residue_t'(rns_residue_t'(v_diff)) *
                                  wide_rns_residue_t'(BINV_MOD_SK), M_SK);
    end
  end

  // --------------------------------------------------------------------------
  // Correction: out = acc_q - alpha*B mod q_j, done as acc_q + (q_j - mag)
  // followed by a single conditional subtract inside add_mod.
  // --------------------------------------------------------------------------
  always_comb begin
    rns_residue_t v_mag;
    for (int s = 0; s < N_SLOTS; s++) begin
      for (int j = 0; j < Q_BASIS_LEN; j++) begin
`ifdef FASTBCONV_SK_CENTER_ALPHA_EN
        if (r_alpha[s] > (M_SK >> 1)) begin
          // alpha stands for the negative value alpha - m_sk: add |alpha'|*B.
          v_mag = mod_reduce(wide_rns_residue_t'(M_SK - r_alpha[s]) *
                             wide_rns_residue_t'(B_MOD_Q[j]), Q_BASIS[j]);
          w_out_nxt[s][j] = add_mod(r_acc_q[s][j], v_mag, Q_BASIS[j]);
        end else begin
          v_mag = mod_reduce(wide_rns_residue_t'(r_alpha[s]) *
                             wide_rns_residue_t'(B_MOD_Q[j]), Q_BASIS[j]);
          w_out_nxt[s][j] = add_mod(r_acc_q[s][j], Q_BASIS[j] - v_mag, Q_BASIS[j]);
        end
`else
        v_mag = mod_reduce(wide_rns_residue_t'(r_alpha[s]) *
                           wide_rns_residue_t'(B_MOD_Q[j]), Q_BASIS[j]);
        w_out_nxt[s][j] = add_mod(r_acc_q[s][j], Q_BASIS[j] - v_mag, Q_BASIS[j]);
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM and all state registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      for (int s = 0; s < N_SLOTS; s++) begin
        for (int i = 0; i < BBA_BASIS_LEN; i++) r_in[s][i] <= '0;
        for (int j = 0; j < Q_BASIS_LEN; j++) begin
          r_acc_q[s][j] <= '0;
          r_out[s][j]   <= '0;
        end
        r_acc_sk[s] <= '0;
        r_alpha[s]  <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            for (int s = 0; s < N_SLOTS; s++) begin
              for (int i = 0; i < BBA_BASIS_LEN; i++) r_in[s][i] <= bus.input_RNSpoly[s][i];
              for (int j = 0; j < Q_BASIS_LEN; j++) r_acc_q[s][j] <= '0;
              r_acc_sk[s] <= '0;
            end
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          for (int s = 0; s < N_SLOTS; s++) begin
            for (int j = 0; j < Q_BASIS_LEN; j++) r_acc_q[s][j] <= w_acc_q_nxt[s][j];
            r_acc_sk[s] <= w_acc_sk_nxt[s];
          end
          if (r_idx == IDX_W'(B_BASIS_LEN - 1)) begin
            r_state <= ST_ALPHA;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_ALPHA: begin
          for (int s = 0; s < N_SLOTS; s++) r_alpha[s] <= w_alpha_nxt[s];
          r_state <= ST_CORRECT;
        end
        ST_CORRECT: begin
          for (int s = 0; s < N_SLOTS; s++) begin
            for (int j = 0; j < Q_BASIS_LEN; j++) r_out[s][j] <= w_out_nxt[s][j];
          end
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fastbconv_sk_bba_to_q.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fastbconv_sk_bba_to_q                                     |
// | Description : Self-checking bench for fastbconv_sk_bba_to_q. Expected      |
// |               values come from plain CRT arithmetic on the toy basis       |
// |               B = {7, 11}, m_sk = 13, q = {5, 3}.                          |
// |               Honours FASTBCONV_SK_CENTER_ALPHA_EN in its reference model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fastbconv_sk_bba_to_q;
  import fastbconv_sk_bba_to_q_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fastbconv_sk_bba_to_q_if bus ();

  fastbconv_sk_bba_to_q dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  int bas_b [2] = '{7, 11};
  int bas_msk   = 13;
  int bas_q [2] = '{5, 3};

  int cur_in  [N_SLOTS][3];
  int cur_exp [N_SLOTS][2];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int posmod(input int a, input int m);
    int r;
    r = a % m;
    if (r < 0) r += m;
    return r;
  endfunction

  function automatic int inv_of(input int a, input int m);
    for (int k = 1; k < m; k++) if (posmod(a * k, m) == 1) return k;
    return 0;
  endfunction

  // Reference: CRT sum over B, exact overflow count from the m_sk residue.
  function automatic int ref_limb(input int r0, input int r1, input int rsk, input int j);
    int big_b, sum, alpha, cof;
    int r [2];
    r[0]  = r0;
    r[1]  = r1;
    big_b = bas_b[0] * bas_b[1];
    sum   = 0;
    for (int i = 0; i < 2; i++) begin
      cof = big_b / bas_b[i];
      sum += posmod(r[i] * inv_of(cof, bas_b[i]), bas_b[i]) * cof;
    end
    alpha = posmod((sum - rsk) * inv_of(big_b, bas_msk), bas_msk);
`ifdef FASTBCONV_SK_CENTER_ALPHA_EN
    if (alpha > bas_msk / 2) alpha -= bas_msk;
`endif
    return posmod(sum - alpha * big_b, bas_q[j]);
  endfunction

  task automatic set_x(input int s, input int x);
    cur_in[s][0]  = x % bas_b[0];
    cur_in[s][1]  = x % bas_b[1];
    cur_in[s][2]  = x % bas_msk;
    cur_exp[s][0] = x % bas_q[0];
    cur_exp[s][1] = x % bas_q[1];
  endtask

  task automatic set_res(input int s, input int r0, input int r1, input int rsk);
    cur_in[s][0] = r0;
    cur_in[s][1] = r1;
    cur_in[s][2] = rsk;
    for (int j = 0; j < 2; j++) cur_exp[s][j] = ref_limb(r0, r1, rsk, j);
  endtask

  task automatic drive_in();
    for (int s = 0; s < N_SLOTS; s++)
      for (int i = 0; i < 3; i++) bus.input_RNSpoly[s][i] = rns_residue_t'(cur_in[s][i]);
  endtask

  // Presents the current input for one edge; returns 1 time unit after it.
  task automatic start_op();
    @(negedge clk);
    drive_in();
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output int busy_hi);
    lat     = 0;
    busy_hi = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy === 1'b1) busy_hi++;
    end
    if (bus.out_valid !== 1'b1) lat = -1;
  endtask

  task automatic check_out(input string tag);
    for (int s = 0; s < N_SLOTS; s++)
      for (int j = 0; j < 2; j++)
        chk($sformatf("%s_s%0d_q%0d", tag, s, j), int'(bus.output_RNSpoly[s][j]), cur_exp[s][j]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bh, acc, cnt, base;

    reset        = 1'b0;
    bus.in_valid = 1'b0;
    for (int s = 0; s < N_SLOTS; s++) begin
      for (int i = 0; i < 3; i++) cur_in[s][i] = 0;
    end
    drive_in();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    acc = 0;
    for (int s = 0; s < N_SLOTS; s++) for (int j = 0; j < 2; j++) acc += int'(bus.output_RNSpoly[s][j]);
    chk("rst_out_zero", acc, 0);
    @(negedge clk);
    reset = 1'b1;

    // x = 40: alpha = 0 path, latency and busy window.
    for (int s = 0; s < N_SLOTS; s++) set_x(s, 40);
    start_op();
    wait_out(lat, bh);
    chk("t1_latency", lat, 4);
    chk("t1_busy_cycles", bh, 4);
    chk("t1_busy_low", int'(bus.busy), 0);
    check_out("t1");
    @(posedge clk);
    #1;
    chk("t1_pulse_one_cycle", int'(bus.out_valid), 0);
    check_out("t1_hold");

    // x = 1: sum over B overflows once, alpha = 1 correction.
    for (int s = 0; s < N_SLOTS; s++) set_x(s, 1);
    start_op();
    wait_out(lat, bh);
    chk("t2_latency", lat, 4);
    check_out("t2");

    // Start pulse while busy is ignored; start in the out_valid cycle is taken.
    for (int s = 0; s < N_SLOTS; s++) set_x(s, 23 + s);
    start_op();
    @(posedge clk);
    #1;
    for (int s = 0; s < N_SLOTS; s++)
      for (int i = 0; i < 3; i++) bus.input_RNSpoly[s][i] = rns_residue_t'(i + s + 1);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_out(lat, bh);
    chk("t3_first_latency", lat, 2);
    check_out("t3_first");
    for (int s = 0; s < N_SLOTS; s++) set_x(s, 60 + s);
    drive_in();
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("t3_b2b_out_valid_drop", int'(bus.out_valid), 0);
    chk("t3_b2b_busy", int'(bus.busy), 1);
    wait_out(lat, bh);
    chk("t3_second_latency", lat, 4);
    check_out("t3_second");

    // Asynchronous reset while in the alpha step aborts the operation.
    for (int s = 0; s < N_SLOTS; s++) set_x(s, 5);
    start_op();
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("t4_busy", int'(bus.busy), 0);
    chk("t4_out_valid", int'(bus.out_valid), 0);
    acc = 0;
    for (int s = 0; s < N_SLOTS; s++) for (int j = 0; j < 2; j++) acc += int'(bus.output_RNSpoly[s][j]);
    chk("t4_out_cleared", acc, 0);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) cnt++;
    end
    chk("t4_no_late_out_valid", cnt, 0);

    // x = 76 at the top of the range, then a vector forcing alpha = 12.
    for (int s = 0; s < N_SLOTS; s++) set_x(s, 76);
    start_op();
    wait_out(lat, bh);
    chk("t5_latency", lat, 4);
    check_out("t5_x76");
    for (int s = 0; s < N_SLOTS; s++) set_res(s, 1, 1, 12);
    start_op();
    wait_out(lat, bh);
    chk("t5_alpha12_latency", lat, 4);
    check_out("t5_alpha12");

    // Random valid x per slot, distinct across slots.
    for (int it = 0; it < 1000; it++) begin
      base = int'($urandom_range(0, 76));
      for (int s = 0; s < N_SLOTS; s++) set_x(s, (base + 19 * s) % 77);
      start_op();
      wait_out(lat, bh);
      chk("t6_latency", lat, 4);
      check_out("t6");
    end

    // Arbitrary residue tuples, including inconsistent m_sk residues.
    for (int it = 0; it < 200; it++) begin
      for (int s = 0; s < N_SLOTS; s++)
        set_res(s, int'($urandom_range(0, 6)), int'($urandom_range(0, 10)),
                int'($urandom_range(0, 12)));
      start_op();
      wait_out(lat, bh);
      chk("t7_latency", lat, 4);
      check_out("t7");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
